// File: rtl/ppu_fetch_stage.sv
// PPU instruction-fetch stage: PC/nPC pair with MIPS delay-slot redirect,
// instruction-memory addressing and the IF/ID pipeline latch.
module ppu_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        le,
  input  logic        flush,
  input  logic        ta_select,
  input  logic [31:0] target_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [31:0] npc_out,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] npc_next;
  logic [31:0] redirect_addr;

  assign redirect_addr = {target_addr[31:2], 2'b00};

  // The redirect lands in nPC, so the word at the old nPC (delay slot) is still fetched.
  always_comb begin
    npc_next = npc + 32'd4;
    if (ta_select) begin
      npc_next = redirect_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      npc <= RESET_PC + 32'd4;
    end else if (le) begin
      pc <= npc;
      npc <= npc_next;
    end
  end

  // Flush clears the latch whether or not the stage is stalled; only real fetches count.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_instr <= 32'h0;
      if_id_pc <= 32'h0;
      if_id_valid <= 1'b0;
      fetch_count <= 32'h0;
    end else if (flush) begin
      if_id_instr <= 32'h0;
      if_id_pc <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (le) begin
      if_id_instr <= imem_data;
      if_id_pc <= pc;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign imem_addr = pc;
  assign npc_out = npc;

endmodule

// File: tb/tb_ppu_fetch_stage.sv
// Self-checking bench for ppu_fetch_stage: two instances (RESET_PC 0 and
// 32'hFFFF_FFF8) driven in lockstep and compared against a fetch-sequence model.
module tb_ppu_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        le;
  logic        flush;
  logic        ta_select;
  logic [31:0] target_addr;
  logic [31:0] imem_data   [2];
  logic [31:0] imem_addr   [2];
  logic [31:0] if_id_instr [2];
  logic [31:0] if_id_pc    [2];
  logic        if_id_valid [2];
  logic [31:0] npc_out     [2];
  logic [31:0] fetch_count [2];

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  logic [31:0] resetPc [2];
  logic [31:0] mPc     [2];
  logic [31:0] mNpc    [2];
  logic [31:0] mInstr  [2];
  logic [31:0] mIfPc   [2];
  logic        mValid  [2];
  logic [31:0] mCount  [2];

  always #5 clk = ~clk;

  // Address-tagged memory contents so every fetched word identifies its address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0] ^ 16'hC0DE, addr[31:16] ^ 16'h0001};
  endfunction

  assign imem_data[0] = memWord(imem_addr[0]);
  assign imem_data[1] = memWord(imem_addr[1]);

  ppu_fetch_stage #(.RESET_PC(RPC0)) dut0 (
    .clk(clk), .reset(reset), .le(le), .flush(flush),
    .ta_select(ta_select), .target_addr(target_addr),
    .imem_data(imem_data[0]), .imem_addr(imem_addr[0]),
    .if_id_instr(if_id_instr[0]), .if_id_pc(if_id_pc[0]),
    .if_id_valid(if_id_valid[0]), .npc_out(npc_out[0]),
    .fetch_count(fetch_count[0])
  );

  ppu_fetch_stage #(.RESET_PC(RPC1)) dut1 (
    .clk(clk), .reset(reset), .le(le), .flush(flush),
    .ta_select(ta_select), .target_addr(target_addr),
    .imem_data(imem_data[1]), .imem_addr(imem_addr[1]),
    .if_id_instr(if_id_instr[1]), .if_id_pc(if_id_pc[1]),
    .if_id_valid(if_id_valid[1]), .npc_out(npc_out[1]),
    .fetch_count(fetch_count[1])
  );

  task automatic checkOne(input string tag, input int k,
                          input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s[dut%0d] observed=%h expected=%h", tag, k, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, and advance the model by the
  // fetch rules: a fetch captures the word at PC, PC takes the old nPC, and nPC
  // moves to the aligned target or the next sequential word.
  task automatic applyStimulus(input logic r, input logic l, input logic f,
                               input logic t, input logic [31:0] tgt);
    logic [31:0] following;
    @(negedge clk);
    reset = r;
    le = l;
    flush = f;
    ta_select = t;
    target_addr = tgt;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mPc[k] = resetPc[k];
        mNpc[k] = resetPc[k] + 32'd4;
        mInstr[k] = 32'h0;
        mIfPc[k] = 32'h0;
        mValid[k] = 1'b0;
        mCount[k] = 32'h0;
      end else begin
        if (f) begin
          mInstr[k] = 32'h0;
          mIfPc[k] = 32'h0;
          mValid[k] = 1'b0;
        end else if (l) begin
          mInstr[k] = memWord(mPc[k]);
          mIfPc[k] = mPc[k];
          mValid[k] = 1'b1;
          mCount[k] = mCount[k] + 32'd1;
        end
        if (l) begin
          following = t ? (tgt & 32'hFFFF_FFFC) : mNpc[k] + 32'd4;
          mPc[k] = mNpc[k];
          mNpc[k] = following;
        end
      end
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOne({tag, ".imem_addr"}, k, imem_addr[k], mPc[k]);
      checkOne({tag, ".npc_out"}, k, npc_out[k], mNpc[k]);
      checkOne({tag, ".if_id_instr"}, k, if_id_instr[k], mInstr[k]);
      checkOne({tag, ".if_id_pc"}, k, if_id_pc[k], mIfPc[k]);
      checkOne({tag, ".if_id_valid"}, k, {31'h0, if_id_valid[k]}, {31'h0, mValid[k]});
      checkOne({tag, ".fetch_count"}, k, fetch_count[k], mCount[k]);
    end
  endtask

  initial begin
    resetPc[0] = RPC0;
    resetPc[1] = RPC1;
    reset = 1'b1;
    le = 1'b0;
    flush = 1'b0;
    ta_select = 1'b0;
    target_addr = 32'h0;

    // Reset, then four sequential fetches; dut1 wraps past the top of memory.
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("reset");
    checkOne("reset_addr", 0, imem_addr[0], 32'h0);
    checkOne("reset_addr", 1, imem_addr[1], 32'hFFFF_FFF8);
    checkOne("reset_npc", 0, npc_out[0], 32'h4);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("seq1");
    checkOne("wrap_fffc", 1, imem_addr[1], 32'hFFFF_FFFC);
    checkOne("seq1_valid", 0, {31'h0, if_id_valid[0]}, 32'h1);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("seq2");
    checkOne("wrap_zero", 1, imem_addr[1], 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      checkOutput("seq");
    end
    checkOne("seq_count", 0, fetch_count[0], 32'd4);
    checkOne("seq_ifpc", 0, if_id_pc[0], 32'd12);
    checkOne("seq_instr", 0, if_id_instr[0], memWord(32'd12));

    // Taken branch at PC=8: delay slot 12, then 0x40, then 0x44.
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOne("br_at8", 0, imem_addr[0], 32'h8);
    applyStimulus(0, 1, 0, 1, 32'h40);
    checkOutput("br_slot");
    checkOne("br_slot", 0, imem_addr[0], 32'hC);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("br_tgt");
    checkOne("br_tgt", 0, imem_addr[0], 32'h40);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOne("br_next", 0, imem_addr[0], 32'h44);

    // Stall at PC=16 with a redirect offered that must be ignored.
    applyStimulus(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h300);
      checkOutput("stall");
    end
    checkOne("stall_pc", 0, imem_addr[0], 32'd16);
    checkOne("stall_npc", 0, npc_out[0], 32'd20);
    checkOne("stall_count", 0, fetch_count[0], 32'd4);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("resume");
    checkOne("resume_ifpc", 0, if_id_pc[0], 32'd16);

    // Flush while stalled, then flush while advancing with a redirect to 0x80.
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("flush_stall");
    checkOne("fs_valid", 0, {31'h0, if_id_valid[0]}, 32'h0);
    checkOne("fs_instr", 0, if_id_instr[0], 32'h0);
    checkOne("fs_pc", 0, imem_addr[0], 32'd20);
    applyStimulus(0, 1, 1, 1, 32'h80);
    checkOutput("flush_adv");
    checkOne("fa_npc", 0, npc_out[0], 32'h80);
    checkOne("fa_count", 0, fetch_count[0], 32'd5);

    // Misaligned target 0x103 fetches from 0x100.
    applyStimulus(0, 1, 0, 1, 32'h103);
    checkOutput("align");
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOne("align_fetch", 0, imem_addr[0], 32'h100);

    // Reset on the edge after a redirect to 0x200 discards the target.
    applyStimulus(0, 1, 0, 1, 32'h200);
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkOutput("rst_redir");
    checkOne("rr_pc", 0, imem_addr[0], 32'h0);
    checkOne("rr_count", 0, fetch_count[0], 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      checkOutput("rr_seq");
    end
    checkOne("rr_after", 0, imem_addr[0], 32'd12);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 4) == 0),
                    $urandom());
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
